booth_mac_accum: RTL



---
 rtl/booth_mac_accum.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/booth_mac_accum.sv
// Multiply-accumulate stage around a radix-4 Booth 16x16 unsigned multiplier.
// Define MAC_SAT_EN to saturate the accumulator and report sticky overflow.

module booth_m (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [31:0] o_p
);
  logic [18:0] w_b_ext;
  logic [31:0] w_a_ext;
  logic [31:0] w_pp;
  logic [31:0] w_sum;
  logic [2:0]  w_grp;

  // Two leading zeros keep the recoded multiplier non-negative.
  assign w_b_ext = {2'b00, i_b, 1'b0};
  assign w_a_ext = {16'd0, i_a};

  // Radix-4 Booth recoding and partial-product summation.
  always_comb begin
    w_sum = 32'd0;
    w_pp  = 32'd0;
    w_grp = 3'd0;
    for (int i = 0; i < 9; i++) begin
      w_grp = w_b_ext[2*i +: 3];
      case (w_grp)
        3'b001, 3'b010: w_pp = w_a_ext;
        3'b011:         w_pp = w_a_ext << 1;
        3'b100:         w_pp = 32'd0 - (w_a_ext << 1);
        3'b101, 3'b110: w_pp = 32'd0 - w_a_ext;
        default:        w_pp = 32'd0;
      endcase
      w_sum = w_sum + (w_pp << (2 * i));
    end
  end

  assign o_p = w_sum;
endmodule

module booth_mac_accum #(
  parameter int MUL_WAIT = 2,
  parameter int ACC_W    = 40,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_x,
  input  logic [15:0]      in_y,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACCUM  = 2'd2,
    OUT    = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [15:0]      r_x;
  logic [15:0]      r_y;
  logic             r_last;
  logic [3:0]       r_wait;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      w_prod;
  logic [ACC_W-1:0] w_acc_next;
  logic [CNT_W-1:0] w_count_inc;
  logic             w_close;

  booth_m u_mul (
    .i_a (r_x),
    .i_b (r_y),
    .o_p (w_prod)
  );

  assign in_ready    = (r_state == IDLE) & ~rst;
  assign out_valid   = (r_state == OUT);
  assign out_acc     = r_acc;
  assign out_count   = r_count;
  assign w_count_inc = r_count + CNT_W'(1);
  // A full counter closes the packet just like in_last.
  assign w_close     = r_last | (&w_count_inc);

`ifdef MAC_SAT_EN
  logic [ACC_W:0] w_sum;
  logic           r_ovf;

  assign w_sum      = {1'b0, r_acc} + (ACC_W+1)'(w_prod);
  assign w_acc_next = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
  assign out_ovf    = r_ovf;

  // Sticky overflow, cleared when the result is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == ACCUM) begin
      r_ovf <= r_ovf | w_sum[ACC_W];
    end else if ((r_state == OUT) && out_ready) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= r_ovf;
    end
  end
`else
  logic [ACC_W-1:0] w_sum;

  assign w_sum      = r_acc + ACC_W'(w_prod);
  assign w_acc_next = w_sum;
  assign out_ovf    = 1'b0;
`endif

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid && in_ready) w_next = SETTLE; else w_next = IDLE;
      SETTLE:  if (r_wait == 4'd1) w_next = ACCUM; else w_next = SETTLE;
      ACCUM:   if (w_close) w_next = OUT; else w_next = IDLE;
      OUT:     if (out_ready) w_next = IDLE; else w_next = OUT;
      default: w_next = IDLE;
    endcase
  end

  // State, operand, wait-counter and accumulator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_x     <= 16'd0;
      r_y     <= 16'd0;
      r_last  <= 1'b0;
      r_wait  <= 4'd0;
      r_acc   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x    <= in_x;
            r_y    <= in_y;
            r_last <= in_last;
            r_wait <= 4'(MUL_WAIT);
          end
        end
        SETTLE: r_wait <= r_wait - 4'd1;
        ACCUM: begin
          r_acc   <= w_acc_next;
          r_count <= w_count_inc;
        end
        OUT: begin
          if (out_ready) begin
            r_acc   <= '0;
            r_count <= '0;
          end
        end
        default: r_wait <= r_wait;
      endcase
    end
  end
endmodule
